// File: rtl/pht_pkg.sv
// rtl/pht_pkg.sv - shared types and counter helpers for the PHT branch predictor
// Contents:
//   state_t    : controller states INIT (table fill) and RUN (normal service)
//   ctr_next   : one saturating step of a counter of width ctr_w (2..4)
//   wnt_value  : weakly-not-taken reset value 2^(ctr_w-1)-1
// Optional feature macro used by the design: PHT_PREDICTOR_GSHARE_EN
package pht_pkg;

  typedef enum logic {INIT, RUN} state_t;

  // Counters are carried at the widest legal width and truncated by the caller.
  localparam int CTR_MAX_W = 4;

  function automatic logic [CTR_MAX_W-1:0] ctr_next(
    input logic [CTR_MAX_W-1:0] ctr,
    input logic                 taken,
    input int                   ctr_w
  );
    logic [CTR_MAX_W-1:0] top;
    top = CTR_MAX_W'((1 << ctr_w) - 1);
    if (taken) begin
      return (ctr == top) ? ctr : ctr + CTR_MAX_W'(1);
    end
    return (ctr == '0) ? ctr : ctr - CTR_MAX_W'(1);
  endfunction

  function automatic logic [CTR_MAX_W-1:0] wnt_value(input int ctr_w);
    return CTR_MAX_W'((1 << (ctr_w - 1)) - 1);
  endfunction

endpackage

// File: rtl/pht_sat_ctr_table.sv
// rtl/pht_sat_ctr_table.sv - array of saturating counters with init, update and read ports
// Ports:
//   clk        : clock, rising edge
//   init_en    : write the weakly-not-taken value to init_idx (has priority)
//   init_idx   : entry being initialised
//   upd_en     : apply one saturating step to upd_idx
//   upd_idx    : entry being updated
//   upd_taken  : step direction (1 = increment, 0 = decrement)
//   rd_idx     : combinational read index
//   rd_ctr     : counter at rd_idx, post-update value when upd_idx matches
// The storage has no reset; the owning controller fills it after every reset.
module pht_sat_ctr_table
  import pht_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int CTR_W = 2
) (
  input  logic             clk,
  input  logic             init_en,
  input  logic [IDX_W-1:0] init_idx,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CTR_W-1:0] rd_ctr
);

  localparam int DEPTH = 1 << IDX_W;

  logic [CTR_W-1:0] mem [DEPTH];
  logic [CTR_W-1:0] upd_next;

  always_comb begin
    upd_next = CTR_W'(ctr_next(CTR_MAX_W'(mem[upd_idx]), upd_taken, CTR_W));
  end

  always_ff @(posedge clk) begin
    if (init_en) begin
      mem[init_idx] <= CTR_W'(wnt_value(CTR_W));
    end else if (upd_en) begin
      mem[upd_idx] <= upd_next;
    end
  end

  // Write-first forwarding: a read that collides with this cycle's update
  // sees the value the update is about to store.
  always_comb begin
    rd_ctr = mem[rd_idx];
    if (upd_en && (upd_idx == rd_idx)) begin
      rd_ctr = upd_next;
    end
  end

endmodule

// File: rtl/pht_predictor.sv
// rtl/pht_predictor.sv - table-of-counters branch direction predictor (bimodal or gshare)
// Optional feature macro: PHT_PREDICTOR_GSHARE_EN (global history XORed into the index)
// Ports:
//   clk, rst    : clock (rising edge) and asynchronous active-high reset
//   ready       : high once every table entry has been initialised
//   req_valid   : lookup request, req_pc : PC of the branch looked up
//   pred_valid  : one cycle after an accepted request
//   pred_taken  : MSB of the selected counter
//   pred_idx    : index used for the lookup, returned later on upd_idx
//   upd_valid   : resolved-outcome write-back, upd_idx / upd_taken : entry and outcome
module pht_predictor
  import pht_pkg::*;
#(
  parameter int PC_W   = 32,
  parameter int PC_LSB = 2,
  parameter int IDX_W  = 6,
  parameter int CTR_W  = 2,
  parameter int HIST_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ready,
  input  logic             req_valid,
  input  logic [PC_W-1:0]  req_pc,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_idx,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  state_t           state;
  state_t           state_nx;
  logic [IDX_W-1:0] init_ptr;
  logic             init_en;
  logic             req_ok;
  logic             upd_ok;
  logic [IDX_W-1:0] pc_slice;
  logic [IDX_W-1:0] idx;
  logic [CTR_W-1:0] rd_ctr;
  logic             unused_pc;

  assign unused_pc = ^req_pc;
  assign pc_slice  = req_pc[PC_LSB+IDX_W-1:PC_LSB];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= INIT;
      init_ptr <= '0;
    end else begin
      state <= state_nx;
      if (state == INIT) begin
        init_ptr <= init_ptr + IDX_W'(1);
      end
    end
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    init_en  = 1'b0;
    req_ok   = 1'b0;
    upd_ok   = 1'b0;
    case (state)
      INIT: begin
        init_en = 1'b1;
        // Leave INIT on the cycle the last entry is written.
        if (init_ptr == '1) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        ready  = 1'b1;
        req_ok = req_valid;
        upd_ok = upd_valid;
      end
      default: state_nx = INIT;
    endcase
  end

`ifdef PHT_PREDICTOR_GSHARE_EN
  logic [HIST_W-1:0] hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= '0;
    end else if (upd_ok) begin
      hist <= HIST_W'({hist, upd_taken});
    end
  end

  // The lookup uses the history before any same-cycle shift.
  assign idx = pc_slice ^ IDX_W'(hist);
`else
  assign idx = pc_slice;
`endif

  pht_sat_ctr_table #(
    .IDX_W (IDX_W),
    .CTR_W (CTR_W)
  ) u_table (
    .clk       (clk),
    .init_en   (init_en),
    .init_idx  (init_ptr),
    .upd_en    (upd_ok),
    .upd_idx   (upd_idx),
    .upd_taken (upd_taken),
    .rd_idx    (idx),
    .rd_ctr    (rd_ctr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_idx   <= '0;
    end else if (req_ok) begin
      pred_valid <= 1'b1;
      pred_taken <= rd_ctr[CTR_W-1];
      pred_idx   <= idx;
    end else begin
      pred_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pht_predictor.sv
// tb/tb_pht_predictor.sv - randomized self-checking bench for pht_predictor against a table model
module tb_pht_predictor;

  localparam int PC_W   = 32;
  localparam int PC_LSB = 2;
  localparam int IDX_W  = 6;
  localparam int CTR_W  = 2;
  localparam int HIST_W = 6;
  localparam int DEPTH  = 1 << IDX_W;
  localparam int CMAX   = (1 << CTR_W) - 1;
  localparam int WNT    = (1 << (CTR_W - 1)) - 1;
  localparam int THRESH = 1 << (CTR_W - 1);

  logic             clk;
  logic             rst;
  logic             ready;
  logic             req_valid;
  logic [PC_W-1:0]  req_pc;
  logic             pred_valid;
  logic             pred_taken;
  logic [IDX_W-1:0] pred_idx;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_taken;

  pht_predictor #(
    .PC_W   (PC_W),
    .PC_LSB (PC_LSB),
    .IDX_W  (IDX_W),
    .CTR_W  (CTR_W),
    .HIST_W (HIST_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ready      (ready),
    .req_valid  (req_valid),
    .req_pc     (req_pc),
    .pred_valid (pred_valid),
    .pred_taken (pred_taken),
    .pred_idx   (pred_idx),
    .upd_valid  (upd_valid),
    .upd_idx    (upd_idx),
    .upd_taken  (upd_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer counters, history and last prediction.
  int m_ctr [DEPTH];
  int m_hist;
  int m_taken;
  int m_idx;

  function automatic int sat_step(input int c, input bit taken);
    int r;
    r = taken ? c + 1 : c - 1;
    if (r > CMAX) r = CMAX;
    if (r < 0) r = 0;
    return r;
  endfunction

  function automatic int model_index(input logic [PC_W-1:0] pc);
    int s;
    s = int'((pc >> PC_LSB) % DEPTH);
`ifdef PHT_PREDICTOR_GSHARE_EN
    s = s ^ m_hist;
`endif
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_ctr[i] = WNT;
    m_hist  = 0;
    m_taken = 0;
    m_idx   = 0;
  endtask

  // One RUN-state cycle with optional lookup and update; checks all outputs.
  task automatic cycle(input bit rv, input logic [PC_W-1:0] pc, input bit uv,
                       input int uidx, input bit ut);
    int e_idx;
    int c;
    req_valid = rv;
    req_pc    = pc;
    upd_valid = uv;
    upd_idx   = IDX_W'(uidx);
    upd_taken = ut;
    if (rv) begin
      e_idx = model_index(pc);
      c = m_ctr[e_idx];
      if (uv && (uidx == e_idx)) c = sat_step(c, ut);
      m_taken = (c >= THRESH) ? 1 : 0;
      m_idx   = e_idx;
    end
    @(posedge clk);
    #1;
    if (uv) begin
      m_ctr[uidx] = sat_step(m_ctr[uidx], ut);
      m_hist = ((m_hist << 1) | int'(ut)) % (1 << HIST_W);
    end
    check("ready", 32'(ready), 32'd1);
    check("pred_valid", 32'(pred_valid), 32'(rv));
    check("pred_taken", 32'(pred_taken), 32'(m_taken));
    check("pred_idx", 32'(pred_idx), 32'(m_idx));
    req_valid = 1'b0;
    upd_valid = 1'b0;
  endtask

  // Hold reset, release, and count cycles until ready while hammering the
  // request/update inputs, which must be ignored during table fill.
  task automatic reset_and_init();
    int n;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_pred_valid", 32'(pred_valid), 32'd0);
    check("rst_pred_taken", 32'(pred_taken), 32'd0);
    check("rst_pred_idx", 32'(pred_idx), 32'd0);
    model_reset();
    req_valid = 1'b1;
    req_pc    = 32'h0000_0014;
    upd_valid = 1'b1;
    upd_idx   = IDX_W'(5);
    upd_taken = 1'b1;
    rst = 1'b0;
    n = 0;
    while (!ready && n < 300) begin
      @(posedge clk);
      #1;
      n++;
      check("init_pred_valid", 32'(pred_valid), 32'd0);
    end
    req_valid = 1'b0;
    upd_valid = 1'b0;
    check("init_cycles", 32'(n), 32'(DEPTH));
  endtask

  task automatic random_phase(input int cycles);
    bit rv, uv, ut;
    int uidx;
    logic [PC_W-1:0] pc;
    for (int i = 0; i < cycles; i++) begin
      rv   = ($urandom_range(0, 3) != 0);
      uv   = ($urandom_range(0, 2) != 0);
      ut   = ($urandom_range(0, 2) != 0);
      uidx = $urandom_range(0, 9);
      pc   = ($urandom & ~32'h0000_00FC) | (PC_W'($urandom_range(0, 9)) << PC_LSB);
      if ($urandom_range(0, 4) == 0) pc = ($urandom & ~32'h0000_00FC) | (PC_W'(uidx) << PC_LSB);
      cycle(rv, pc, uv, uidx, ut);
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_pc    = '0;
    upd_valid = 1'b0;
    upd_idx   = '0;
    upd_taken = 1'b0;

    reset_and_init();

    // First lookup after init reads weakly-not-taken.
    cycle(1'b1, $urandom, 1'b0, 0, 1'b0);
    check("first_lookup", 32'(pred_taken), 32'd0);

    // Same-cycle update and lookup of entry 2 (counter 1 -> forwarded 2).
    cycle(1'b1, 32'h0000_0008, 1'b1, 2, 1'b1);
    check("fwd_taken", 32'(pred_taken), 32'd1);

    // Three taken updates to entry 5, lookup, then saturation.
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 5, 1'b1);
    cycle(1'b1, 32'h0000_0014, 1'b0, 0, 1'b0);
    check("idx5_taken", 32'(pred_taken), 32'd1);
`ifndef PHT_PREDICTOR_GSHARE_EN
    check("idx5_idx", 32'(pred_idx), 32'd5);
`endif
    cycle(1'b0, '0, 1'b1, 5, 1'b1);
    cycle(1'b0, '0, 1'b1, 5, 1'b0);
    cycle(1'b1, 32'h0000_0014, 1'b0, 0, 1'b0);
    check("idx5_sat", 32'(pred_taken), 32'd1);
    cycle(1'b0, '0, 1'b1, 5, 1'b0);
    cycle(1'b1, 32'h0000_0014, 1'b0, 0, 1'b0);
    check("idx5_down", 32'(pred_taken), 32'd0);

    random_phase(400);

    // Reset during a lookup: outputs drop without waiting for a clock edge.
    cycle(1'b1, 32'h0000_0010, 1'b0, 0, 1'b0);
    req_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("async_pred_valid", 32'(pred_valid), 32'd0);
    check("async_ready", 32'(ready), 32'd0);
    check("async_pred_idx", 32'(pred_idx), 32'd0);
    reset_and_init();

    // Every entry must read back weakly-not-taken.
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, PC_W'(i) << PC_LSB, 1'b0, 0, 1'b0);
    end

    random_phase(400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
